// File: rtl/max_pooling_unit.sv
// Streaming KxK max-pool over a ROW_SIZE x ROW_SIZE map held in a sync-read BRAM.
// Define MAX_POOL_SIGNED_EN for a two's-complement compare (default: unsigned).
module max_pooling_unit #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 2,
  parameter int ROW_SIZE   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en
);

  localparam int K   = KERNEL_DIM;
  localparam int OUT = ROW_SIZE / KERNEL_DIM;
  localparam int KCW = $clog2(K*K + 1);
  localparam int OIW = $clog2(OUT*OUT + 1);
  localparam logic [KCW-1:0] KK = KCW'(K*K);
  localparam logic [OIW-1:0] OLAST = OIW'(OUT*OUT - 1);

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] col;
  logic [KCW-1:0]        kern_count;
  logic [OIW-1:0]        out_idx;
  logic [DATA_WIDTH-1:0] max_val;
  logic [31:0]           offset;
  logic                  gt;
  logic                  wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= READ;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      READ:  if (kern_count == KK) state_nx = WRITE;
      WRITE: state_nx = (out_idx == OLAST) ? DONE : READ;
      DONE:  state_nx = DONE;
      default: state_nx = READ;
    endcase
  end

  always_comb begin
    offset = (32'(kern_count) / K) * ROW_SIZE + 32'(kern_count) % K;
    rd_addr = base_addr;
    if (state == DONE)
      rd_addr = '0;
    else if (kern_count < KK)
      rd_addr = ADDR_WIDTH'(32'(base_addr) + offset);
  end

`ifdef MAX_POOL_SIGNED_EN
  assign gt = $signed(rd_data) > $signed(max_val);
`else
  assign gt = rd_data > max_val;
`endif

  // Next window would run past the last full column: wrap to next band.
  assign wrap = (32'(col) + 2*K) > ROW_SIZE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_addr  <= '0;
      col        <= '0;
      kern_count <= '0;
      out_idx    <= '0;
      max_val    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      unique case (state)
        READ: begin
          wr_en <= 1'b0;
          if (kern_count != KK)
            kern_count <= kern_count + 1'b1;
          if (kern_count == KCW'(1))
            max_val <= rd_data;
          else if (kern_count > KCW'(1) && gt)
            max_val <= rd_data;
        end
        WRITE: begin
          wr_en      <= 1'b1;
          wr_addr    <= ADDR_WIDTH'(out_idx);
          wr_data    <= max_val;
          kern_count <= '0;
          out_idx    <= out_idx + 1'b1;
          if (wrap) begin
            col       <= '0;
            base_addr <= ADDR_WIDTH'(32'(base_addr) - 32'(col)
                         + K*ROW_SIZE);
          end else begin
            col       <= col + ADDR_WIDTH'(K);
            base_addr <= base_addr + ADDR_WIDTH'(K);
          end
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_max_pooling_unit.sv
// Directed bench for max_pooling_unit: BRAM models, write capture,
// cycle timing, reset restart and compare-mode checks.
module tb_max_pooling_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;

  int checks = 0;
  int failures = 0;

  logic [7:0] in_mem [64];
  logic [7:0] wr_datas [16];
  logic [5:0] wr_addrs [16];
  int         wr_cyc [16];
  logic [5:0] rd_seq [80];
  int         cyc;
  int         wr_cnt;

  logic [7:0] p1 [36] = '{
    1, 3, 5, 7, 9, 11,
    2, 4, 6, 8, 10, 12,
    13, 15, 17, 19, 21, 23,
    14, 16, 18, 20, 22, 24,
    25, 27, 29, 31, 33, 35,
    26, 28, 30, 32, 34, 36};
  logic [7:0] e1 [9] = '{4, 8, 12, 16, 20, 24, 28, 32, 36};
  int offs [4] = '{0, 1, 6, 7};

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= in_mem[rd_addr];

  max_pooling_unit dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (cyc < 80) rd_seq[cyc] = rd_addr;
      @(posedge clk);
      @(negedge clk);
      if (wr_en) begin
        if (wr_cnt < 16) begin
          wr_cyc[wr_cnt]   = cyc;
          wr_addrs[wr_cnt] = wr_addr;
          wr_datas[wr_cnt] = wr_data;
        end
        wr_cnt++;
      end
      cyc++;
    end
  endtask

  task automatic start();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    wr_cnt = 0;
  endtask

  task automatic check_p1(input string tag);
    check({tag, "_cnt"}, wr_cnt, 9);
    for (int i = 0; i < 9; i++) begin
      check({tag, "_addr"}, wr_addrs[i], i);
      check({tag, "_data"}, wr_datas[i], e1[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) in_mem[i] = 8'd0;
    for (int i = 0; i < 36; i++) in_mem[i] = p1[i];
    cyc = 0;
    wr_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);

    // Main run with timing
    start();
    run(70);
    check_p1("p1");
    check("rd0", rd_seq[0], 0);
    check("rd1", rd_seq[1], 1);
    check("rd2", rd_seq[2], 6);
    check("rd3", rd_seq[3], 7);
    check("rd6", rd_seq[6], 2);
    check("rd7", rd_seq[7], 3);
    check("rd8", rd_seq[8], 8);
    check("rd9", rd_seq[9], 9);
    check("first_wr_cyc", wr_cyc[0], 5);
    check("last_wr_cyc", wr_cyc[8], 53);
    for (int i = 1; i < 9; i++)
      check("wr_spacing", wr_cyc[i] - wr_cyc[i-1], 6);
    check("done_rd_addr", rd_seq[60], 0);
    check("done_wr_en", wr_en, 0);

    // All-zero input
    for (int i = 0; i < 64; i++) in_mem[i] = 8'd0;
    start();
    run(60);
    check("zero_cnt", wr_cnt, 9);
    for (int i = 0; i < 9; i++) check("zero_data", wr_datas[i], 0);

    // 200 at a different corner of each window
    for (int w = 0; w < 9; w++) begin
      int b;
      b = (w / 3) * 12 + (w % 3) * 2;
      for (int j = 0; j < 4; j++) in_mem[b + offs[j]] = 8'(w + 1);
      in_mem[b + offs[w % 4]] = 8'd200;
    end
    start();
    run(60);
    check("corner_cnt", wr_cnt, 9);
    for (int i = 0; i < 9; i++) check("corner_data", wr_datas[i], 200);

    // Reset after the 4th write, then restart
    for (int i = 0; i < 36; i++) in_mem[i] = p1[i];
    start();
    for (int i = 0; i < 100; i++) if (wr_cnt < 4) run(1);
    check("mid_wr_cnt", wr_cnt, 4);
    check("mid_wr_data", wr_data, 16);
    rst = 1'b1;
    #1;
    check("async_wr_en", wr_en, 0);
    check("async_wr_data", wr_data, 0);
    check("async_wr_addr", wr_addr, 0);
    check("async_rd_addr", rd_addr, 0);
    @(posedge clk);
    @(negedge clk);
    check("held_rd_addr", rd_addr, 0);
    check("held_wr_en", wr_en, 0);
    rst = 1'b0;
    cyc = 0;
    wr_cnt = 0;
    run(60);
    check_p1("restart");
    check("restart_first_cyc", wr_cyc[0], 5);

    // Signedness window
    for (int i = 0; i < 64; i++) in_mem[i] = 8'd0;
    in_mem[0] = 8'hFF;
    in_mem[1] = 8'h01;
    in_mem[6] = 8'h80;
    in_mem[7] = 8'h00;
    start();
    run(60);
    check("sgn_cnt", wr_cnt, 9);
`ifdef MAX_POOL_SIGNED_EN
    check("sgn_win0", wr_datas[0], 8'h01);
`else
    check("sgn_win0", wr_datas[0], 8'hFF);
`endif
    check("sgn_win1", wr_datas[1], 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
